// File: rtl/enum_walker.sv
// Command-driven walker over the family enumeration (sparse int encoding).
// Validates raw loads, steps next/prev, and streams each visited member with its ordinal.
module enum_walker #(
  parameter bit WRAP  = 1'b1,
  parameter int RUN_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_value,
  output logic [3:0]  out_index,
  output logic        out_last,
  output logic        err_illegal,
  output logic        busy
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_FWD  = 2'd1;
  localparam logic [1:0] OP_BWD  = 2'd2;
  localparam logic [1:0] OP_RUN  = 2'd3;
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_ZERO = '0;

  state_t           state_q, state_d;
  logic [3:0]       cur_q, cur_d;
  logic [RUN_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;

  function automatic logic [31:0] ord_to_val(input logic [3:0] o);
    case (o)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: ord_to_val = {28'd0, o};
      4'd6, 4'd7, 4'd8:                   ord_to_val = 32'd4 + {28'd0, o};
      4'd9, 4'd10, 4'd11, 4'd12:          ord_to_val = 32'd11 + {28'd0, o};
      default:                            ord_to_val = 32'd17 + {28'd0, o};
    endcase
  endfunction

  // Returns {legal, ordinal}; anything outside the member set (including negatives) is illegal.
  function automatic logic [4:0] val_to_ord(input logic [31:0] v);
    if (v <= 32'd5)                       val_to_ord = {1'b1, v[3:0]};
    else if (v >= 32'd10 && v <= 32'd12)  val_to_ord = {1'b1, 4'(v - 32'd4)};
    else if (v >= 32'd20 && v <= 32'd23)  val_to_ord = {1'b1, 4'(v - 32'd11)};
    else if (v >= 32'd30 && v <= 32'd32)  val_to_ord = {1'b1, 4'(v - 32'd17)};
    else                                  val_to_ord = 5'd0;
  endfunction

  function automatic logic at_end(input logic [3:0] o, input logic bwd);
    at_end = bwd ? (o == 4'd0) : (o == 4'd15);
  endfunction

  function automatic logic [3:0] step(input logic [3:0] o, input logic bwd);
    if (!WRAP && at_end(o, bwd)) step = o;
    else                         step = bwd ? o - 4'd1 : o + 4'd1;
  endfunction

  logic [4:0]       load_chk;
  logic [RUN_W-1:0] run_n;
  logic             accept;

  assign load_chk = val_to_ord(cmd_arg);
  assign run_n    = cmd_arg[RUN_W-1:0];
  assign accept   = cmd_valid && ready_q;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    last_d  = last_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD: begin
              if (load_chk[4]) begin
                cur_d   = load_chk[3:0];
                last_d  = 1'b1;
                state_d = S_EMIT;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_FWD, OP_BWD: begin
              cur_d   = step(cur_q, cmd_op == OP_BWD);
              last_d  = 1'b1;
              state_d = S_EMIT;
            end
            OP_RUN: begin
              if (run_n != RUN_ZERO) begin
                dir_d   = cmd_arg[31];
                cur_d   = step(cur_q, cmd_arg[31]);
                rem_d   = run_n - RUN_ONE;
                // Saturating mode ends the run once the end member has been emitted.
                last_d  = (run_n == RUN_ONE) || (!WRAP && at_end(cur_d, cmd_arg[31]));
                state_d = S_EMIT;
              end
            end
            default: ;
          endcase
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            last_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            cur_d  = step(cur_q, dir_q);
            rem_d  = rem_q - RUN_ONE;
            last_d = (rem_q == RUN_ONE) || (!WRAP && at_end(cur_d, dir_q));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= 4'd0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign out_valid   = (state_q == S_EMIT);
  assign busy        = (state_q != S_IDLE);
  assign out_index   = cur_q;
  assign out_value   = ord_to_val(cur_q);
  assign out_last    = last_q;
  assign err_illegal = err_q;

endmodule
